// File: rtl/sipo_frame_pkg.sv
// Shared types and framing constants for the serial frame receiver.
package sipo_frame_pkg;

  // Receiver FSM states; ST_PARITY is only reachable in parity builds.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register: keeps the last good word under a valid/ack
// handshake and flags words dropped while the consumer has not acknowledged.
module sipo_out_reg #(
  parameter int unsigned NBIT = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            good_frame,
  input  logic [NBIT-1:0] word_in,
  input  logic            rd_ack,
  output logic [NBIT-1:0] data_out,
  output logic            data_valid,
  output logic            overrun
);

  logic [NBIT-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  // Next-state: a good frame loads if the slot is free or being acked this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (good_frame) begin
      if (!valid_q || rd_ack) begin
        data_d    = word_in;
        valid_d   = 1'b1;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit 1, NBIT data bits LSB first,
// optional even-parity bit, stop bit 0.
// Define SIPO_FRAME_RX_PARITY_EN to enable the parity bit and parity_err.
module sipo_frame_rx
  import sipo_frame_pkg::*;
#(
  parameter int unsigned NBIT = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            data_in,
  input  logic            rd_ack,
  output logic [NBIT-1:0] data_out,
  output logic            data_valid,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned   CW       = $clog2(NBIT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBIT - 1);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NBIT-1:0] shreg_q, shreg_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;
  logic            good_frame;
  logic            stop_ok;
  logic            par_ok;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            parity_err_q, parity_err_d;
`endif

  // FSM next-state, shifter and error-pulse decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    good_frame  = 1'b0;
    stop_ok     = (data_in == STOP_BIT);
`ifdef SIPO_FRAME_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
    par_ok       = ((^shreg_q) == par_bit_q);
`else
    par_ok       = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_in == START_BIT) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        shreg_d[cnt_q] = data_in;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
`ifdef SIPO_FRAME_RX_PARITY_EN
        par_bit_d = data_in;
        state_d   = ST_STOP;
`else
        state_d   = ST_IDLE;
`endif
      end
      ST_STOP: begin
        // Stop bit is consumed here; a 1 is an error, never a new start.
        state_d     = ST_IDLE;
        frame_err_d = !stop_ok;
`ifdef SIPO_FRAME_RX_PARITY_EN
        parity_err_d = !par_ok;
`endif
        good_frame  = stop_ok && par_ok;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, shifter and registered status outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sipo_out_reg #(
    .NBIT(NBIT)
  ) u_out_reg (
    .clk       (clk),
    .clr       (clr),
    .good_frame(good_frame),
    .word_in   (shreg_q),
    .rd_ack    (rd_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx: stimulus queues the expected output
// tuple and the edge it should appear on; a negedge monitor pops on change.
module tb_sipo_frame_rx;

  localparam int unsigned NBIT = 5;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int FL = NBIT + 3;
`else
  localparam int FL = NBIT + 2;
`endif

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            data_in = 1'b0;
  logic            rd_ack = 1'b0;
  logic [NBIT-1:0] data_out;
  logic            data_valid;
  logic            frame_err;
  logic            parity_err;
  logic            overrun;
  logic            busy;

  sipo_frame_rx #(
    .NBIT(NBIT)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .data_in   (data_in),
    .rd_ack    (rd_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // {data_valid, frame_err, parity_err, overrun, data_out}
  typedef struct {
    int               cyc;
    logic [NBIT+3:0]  val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [NBIT+3:0] prev = '0;
  logic [NBIT+3:0] cur;
  exp_t            e;

  always @(negedge clk) begin
    if (!clr) begin
      prev = '0;
    end else begin
      cur = {data_valid, frame_err, parity_err, overrun, data_out};
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required unchanged %b", cur, cyc, prev);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            errors++;
            $display("FAIL out_tuple: got %b at cycle %0d, required %b at cycle %0d", cur, cyc, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic expect_at(input int at, input logic dv, input logic [NBIT-1:0] d,
                           input logic fe, input logic pe, input logic ov);
    exp_t x;
    x.cyc = at;
    x.val = {dv, fe, pe, ov, d};
    sb.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [NBIT-1:0] w, input logic stopb,
                       input logic bad_par, input logic ack_stop);
    logic pbit;
    pbit = (^w) ^ bad_par;
    drive(1'b1);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < int'(NBIT); i++) drive(w[i]);
`ifdef SIPO_FRAME_RX_PARITY_EN
    drive(pbit);
`endif
    rd_ack = ack_stop;
    drive(stopb);
    rd_ack  = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic ack_word(input logic [NBIT-1:0] held);
    expect_at(cyc + 1, 1'b0, held, 1'b0, 1'b0, 1'b0);
    rd_ack = 1'b1;
    drive(1'b0);
    rd_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({data_valid, frame_err, parity_err, overrun, data_out}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    clr = 1'b1;
    drive(1'b0);
    drive(1'b0);

    // Good frame 01101.
    expect_at(cyc + FL, 1'b1, 5'b01101, 1'b0, 1'b0, 1'b0);
    frame(5'b01101, 1'b0, 1'b0, 1'b0);
    check("busy_after_frame", 32'(busy), 32'd0);
    ack_word(5'b01101);

    // Stop bit 1: frame_err pulse, word discarded, stop not seen as start.
    expect_at(cyc + FL,     1'b0, 5'b01101, 1'b1, 1'b0, 1'b0);
    expect_at(cyc + FL + 1, 1'b0, 5'b01101, 1'b0, 1'b0, 1'b0);
    frame(5'b01101, 1'b1, 1'b0, 1'b0);
    check("busy_after_bad_stop", 32'(busy), 32'd0);
    drive(1'b0);
    check("idle_after_bad_stop", 32'(busy), 32'd0);

    // Back-to-back, no ack: second word dropped, overrun set.
    expect_at(cyc + FL,     1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    expect_at(cyc + 2 * FL, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b1);
    frame(5'b00011, 1'b0, 1'b0, 1'b0);
    frame(5'b10100, 1'b0, 1'b0, 1'b0);
    drive(1'b0);
    ack_word(5'b00011);

    // Back-to-back with ack on the second stop edge: new word loads.
    expect_at(cyc + FL,     1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    expect_at(cyc + 2 * FL, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    frame(5'b00011, 1'b0, 1'b0, 1'b0);
    frame(5'b10100, 1'b0, 1'b0, 1'b1);
    drive(1'b0);
    ack_word(5'b10100);

    // Ack while nothing is valid is ignored.
    rd_ack = 1'b1;
    drive(1'b0);
    rd_ack = 1'b0;
    check("ack_when_empty", 32'(data_valid), 32'd0);

    // Reset mid-frame after 3 data bits.
    expect_at(cyc + FL, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    frame(5'b11111, 1'b0, 1'b0, 1'b0);
    drive(1'b1);
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    check("busy_before_clr", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    check("clr_outputs", 32'({data_valid, frame_err, parity_err, overrun, data_out}), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    drive(1'b0);
    expect_at(cyc + FL, 1'b1, 5'b10010, 1'b0, 1'b0, 1'b0);
    frame(5'b10010, 1'b0, 1'b0, 1'b0);
    ack_word(5'b10010);

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Wrong parity, good stop: parity_err only.
    expect_at(cyc + FL,     1'b0, 5'b10010, 1'b0, 1'b1, 1'b0);
    expect_at(cyc + FL + 1, 1'b0, 5'b10010, 1'b0, 1'b0, 1'b0);
    frame(5'b01101, 1'b0, 1'b1, 1'b0);
    // Wrong parity and bad stop: both pulses.
    expect_at(cyc + FL,     1'b0, 5'b10010, 1'b1, 1'b1, 1'b0);
    expect_at(cyc + FL + 1, 1'b0, 5'b10010, 1'b0, 1'b0, 1'b0);
    frame(5'b01101, 1'b1, 1'b1, 1'b0);
    drive(1'b0);
`endif

    repeat (3) drive(1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
